stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Time-keeping stage directly downstream of the 1 Hz / 2 Hz rate-select stage.
- Takes the selected slow clock as a data signal and synchronises it into the master clock domain. Each rising edge becomes a one-cycle tick.
- Each tick advances a MM:SS BCD counter according to run/adjust/pause state.
- Drives the BCD digits consumed by the seven-segment display driver.

Parameters:
- SYNC_STAGES, 2, number of flops in the tick_in synchroniser (minimum 2).
- WRAP_AT_MAX, 1, 1 = 59:59 rolls to 00:00 in run mode; 0 = counter holds at 59:59.

Ports:
- clock  input  1  master system clock (100 MHz board clock); all state on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  selected slow clock from the rate-select stage (1 Hz or 2 Hz), asynchronous to clock.
- adj  input  1  1 = adjust mode; 0 = run mode.
- sel  input  1  adjust target: 0 = minutes, 1 = seconds.
- pause_toggle  input  1  one-cycle pulse, already debounced upstream; toggles the paused state.
- clear  input  1  synchronous clear of the time digits.
- sec_ones  output  4  BCD seconds units, 0-9.
- sec_tens  output  4  BCD seconds tens, 0-5.
- min_ones  output  4  BCD minutes units, 0-9.
- min_tens  output  4  BCD minutes tens, 0-5.
- paused  output  1  current paused state.
- tick_pulse  output  1  one-cycle strobe for each accepted tick_in rising edge; debug and blink use.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All digits 0.
  - paused=0, tick_pulse=0.
  - Synchroniser flops and edge-detect flop 0.
  - Takes effect immediately and releases on the next clock edge after deassertion.
  - A tick in flight when reset asserts is discarded.
- Synchroniser and edge detect:
  - tick_in passes through SYNC_STAGES flops, then one history flop.
  - tick_pulse = last sync stage & ~history.
  - If tick_in is first sampled high at edge k, tick_pulse is high during the cycle after edge k+SYNC_STAGES-1.
  - Digits update at edge k+SYNC_STAGES. With the default, that is the 3rd edge counting k.
  - Exactly one pulse per tick_in rising edge, however long tick_in stays high.
- Paused state:
  - paused toggles on every cycle in which pause_toggle=1.
  - A tick in the same cycle is evaluated against the paused value before the toggle.
- Priority per cycle, highest first:
  1. clear: all digits become 0 at the next edge. paused is unchanged. A coincident tick is dropped.
  2. paused=1: digits hold. The tick is dropped, not queued.
  3. tick_pulse=1 with adj=0 (run mode):
     - sec_ones+1. At 9 it wraps to 0 and carries into sec_tens.
     - sec_tens at 5 with a carry wraps to 0 and carries into min_ones.
     - min_ones at 9 wraps to 0 and carries into min_tens.
     - min_tens at 5 with a carry: if WRAP_AT_MAX=1 the counter goes to 00:00; if 0, all digits hold at 59:59.
  4. tick_pulse=1 with adj=1 (adjust mode):
     - sel=1: seconds field increments mod 60 (59 goes to 00). No carry into minutes.
     - sel=0: minutes field increments mod 60 with the seconds field unchanged. Wrap is unconditional; WRAP_AT_MAX does not apply.
     - adj and sel are sampled in the tick_pulse cycle. Changing them between ticks has no other effect.
  5. Otherwise: hold.
- All outputs are registered except tick_pulse. No digit ever takes a value outside its stated range.
- Width rules:
  - Increments are computed on 4-bit BCD digits with explicit compare-to-9/5 wrap. No binary-to-BCD conversion.
  - A field carry_out fires only when the field actually wraps and the increment is enabled.

Decomposition:
- Shared package stopwatch_pkg:
  - digit limits: ONES_MAX=9, TENS_MAX=5;
  - typedef bcd_t (4-bit);
  - typedef mmss_t struct {min_tens, min_ones, sec_tens, sec_ones}.
- One sub-module, bcd_mod60:
  - ports: clock, reset_n, clear, inc, tens/ones outputs, carry_out;
  - instantiated twice, for seconds and minutes.
  - Top level holds the synchroniser, edge detect, pause flop, mode/priority logic and the WRAP_AT_MAX hold.

Test Plan:
- Reset then 3 tick_in rising edges, run mode -> digits 00:03. Each update lands exactly SYNC_STAGES edges after tick_in is first sampled high. tick_pulse is one cycle wide even with tick_in held high for 1000 cycles.
- Preload to 00:59 by ticking, then 1 tick -> 01:00. Preload 59:59 then 1 tick: WRAP_AT_MAX=1 -> 00:00; WRAP_AT_MAX=0 -> stays 59:59.
- adj=1, sel=1 at 00:58 with 3 ticks -> 00:59, 00:00, 00:01, minutes never change. adj=1, sel=0 at 58:30 with 2 ticks -> 59:30, 00:30.
- pause_toggle pulse, then 5 ticks -> digits frozen, paused=1. Second pulse then 2 ticks -> +2. pause_toggle in the same cycle as tick_pulse while running -> that tick is counted.
- clear coincident with tick_pulse at 12:34 -> 00:00 with the tick dropped, and paused keeps its value.
- reset_n pulsed low mid-count at 07:07 with no clock edge -> outputs 0 immediately. A tick_in edge sampled two cycles before reset produces no increment after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared digit limits and time-field types for the MM:SS stopwatch.
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t ONES_MAX = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;
endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD mod-60 field (00..59) with synchronous clear and wrap carry.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry_out
);
  // Carry only when this field actually wraps 59 -> 00 on an enabled increment.
  assign carry_out = inc && (ones == ONES_MAX) && (tens == TENS_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clear) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (ones == ONES_MAX) begin
        ones <= '0;
        tens <= (tens == TENS_MAX) ? bcd_t'(0) : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end
endmodule

// File: rtl/stopwatch_counter.sv
// Slow-tick synchroniser, edge detect, pause and run/adjust control for an MM:SS BCD stopwatch.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP_AT_MAX = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       adj,
  input  logic       sel,
  input  logic       pause_toggle,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       paused,
  output logic       tick_pulse
);
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   history;
  logic                   live, run_tick, hold_max;
  logic                   sec_inc, min_inc, sec_carry, min_carry;
  mmss_t                  cur;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_pipe <= '0;
      history   <= 1'b0;
      paused    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], tick_in};
      history   <= sync_pipe[SYNC_STAGES-1];
      paused    <= paused ^ pause_toggle;
    end
  end

  assign tick_pulse = sync_pipe[SYNC_STAGES-1] & ~history;

  // clear and paused both swallow the tick; paused is the pre-toggle value.
  assign live     = tick_pulse & ~paused & ~clear;
  assign run_tick = live & ~adj;
  assign hold_max = run_tick && !WRAP_AT_MAX &&
                    (cur.min_tens == TENS_MAX) && (cur.min_ones == ONES_MAX) &&
                    (cur.sec_tens == TENS_MAX) && (cur.sec_ones == ONES_MAX);

  // Adjust mode never carries seconds into minutes.
  assign sec_inc = (run_tick & ~hold_max) | (live & adj & sel);
  assign min_inc = (sec_carry & ~adj) | (live & adj & ~sel);

  bcd_mod60 u_sec (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .inc       (sec_inc),
    .tens      (cur.sec_tens),
    .ones      (cur.sec_ones),
    .carry_out (sec_carry)
  );

  bcd_mod60 u_min (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .inc       (min_inc),
    .tens      (cur.min_tens),
    .ones      (cur.min_ones),
    .carry_out (min_carry)
  );

  // Minute wrap is handled inside the field; its carry has no consumer.
  logic unused_min_carry;
  assign unused_min_carry = min_carry;

  assign sec_ones = cur.sec_ones;
  assign sec_tens = cur.sec_tens;
  assign min_ones = cur.min_ones;
  assign min_tens = cur.min_tens;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed scoreboard bench: one wrapping and one holding stopwatch driven in parallel.
module tb_stopwatch_counter;
  logic clock = 1'b0;
  logic reset_n, tick_in, adj, sel, pause_toggle, clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0] h_sec_ones, h_sec_tens, h_min_ones, h_min_tens;
  logic paused, tick_pulse, h_paused, h_tick_pulse;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  int m_exp = 0, s_exp = 0;
  bit paused_exp = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clock = ~clock;

  stopwatch_counter #(.SYNC_STAGES(2), .WRAP_AT_MAX(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .tick_in(tick_in), .adj(adj), .sel(sel),
    .pause_toggle(pause_toggle), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .paused(paused), .tick_pulse(tick_pulse)
  );

  stopwatch_counter #(.SYNC_STAGES(2), .WRAP_AT_MAX(1'b0)) dut_hold (
    .clock(clock), .reset_n(reset_n), .tick_in(tick_in), .adj(adj), .sel(sel),
    .pause_toggle(pause_toggle), .clear(clear),
    .sec_ones(h_sec_ones), .sec_tens(h_sec_tens), .min_ones(h_min_ones), .min_tens(h_min_tens),
    .paused(h_paused), .tick_pulse(h_tick_pulse)
  );

  always @(negedge clock) if (tick_pulse) pulse_cnt <= pulse_cnt + 1;

  function automatic logic [15:0] pack(input int m, input int s);
    pack = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_time(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {min_tens, min_ones, sec_tens, sec_ones}, e);
    end
  endtask

  // Independent reference for a single accepted tick (wrapping variant).
  task automatic model_tick();
    if (!paused_exp) begin
      if (adj) begin
        if (sel) s_exp = (s_exp + 1) % 60;
        else     m_exp = (m_exp + 1) % 60;
      end else if (s_exp == 59) begin
        s_exp = 0;
        m_exp = (m_exp + 1) % 60;
      end else begin
        s_exp = s_exp + 1;
      end
    end
  endtask

  task automatic do_tick(input string tag);
    model_tick();
    exp_q.push_back(pack(m_exp, s_exp));
    @(negedge clock) tick_in = 1'b1;
    repeat (3) @(negedge clock);
    tick_in = 1'b0;
    repeat (2) @(negedge clock);
    chk_time(tag);
  endtask

  task automatic do_clear();
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    m_exp = 0; s_exp = 0;
  endtask

  task automatic pulse_pause();
    @(negedge clock) pause_toggle = 1'b1;
    @(negedge clock) pause_toggle = 1'b0;
    paused_exp = ~paused_exp;
  endtask

  task automatic set_time(input int m, input int s);
    do_clear();
    adj = 1'b1; sel = 1'b0;
    for (int i = 0; i < m; i++) do_tick("preload_min");
    sel = 1'b1;
    for (int i = 0; i < s; i++) do_tick("preload_sec");
    adj = 1'b0;
  endtask

  initial begin
    int p0;
    reset_n = 1'b0; tick_in = 1'b0; adj = 1'b0; sel = 1'b0;
    pause_toggle = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    chk("reset_paused", {15'd0, paused}, 16'd0);
    chk("reset_pulse", {15'd0, tick_pulse}, 16'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Exact latency: first sample at edge k, pulse after k+1, digits at k+2.
    p0 = pulse_cnt;
    @(negedge clock) tick_in = 1'b1;
    @(posedge clock); #1;
    chk("lat_k_pulse", {15'd0, tick_pulse}, 16'd0);
    @(posedge clock); #1;
    chk("lat_k1_pulse", {15'd0, tick_pulse}, 16'd1);
    chk("lat_k1_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    @(posedge clock); #1;
    chk("lat_k2_pulse", {15'd0, tick_pulse}, 16'd0);
    chk("lat_k2_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0001);
    repeat (1000) @(negedge clock);
    tick_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("long_high_one_pulse", 16'(pulse_cnt - p0), 16'd1);
    s_exp = 1;
    do_tick("run_2");
    do_tick("run_3");

    // Seconds to minutes carry.
    for (int i = 3; i < 59; i++) do_tick("run_fill");
    chk("at_00_59", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
    do_tick("carry_01_00");

    // 59:59 boundary: wrapping instance rolls over, holding instance sticks.
    set_time(59, 59);
    chk("hold_pre", {h_min_tens, h_min_ones, h_sec_tens, h_sec_ones}, 16'h5959);
    do_tick("wrap_00_00");
    chk("hold_59_59", {h_min_tens, h_min_ones, h_sec_tens, h_sec_ones}, 16'h5959);
    do_tick("wrap_next");
    chk("hold_still", {h_min_tens, h_min_ones, h_sec_tens, h_sec_ones}, 16'h5959);

    // Adjust seconds without carry.
    set_time(0, 58);
    adj = 1'b1; sel = 1'b1;
    do_tick("adj_sec_59");
    do_tick("adj_sec_00");
    do_tick("adj_sec_01");

    // Adjust minutes with seconds untouched.
    set_time(58, 30);
    adj = 1'b1; sel = 1'b0;
    do_tick("adj_min_59");
    do_tick("adj_min_00");
    adj = 1'b0;

    // Pause freezes digits and drops ticks.
    pulse_pause();
    chk("paused_set", {15'd0, paused}, {15'd0, paused_exp});
    for (int i = 0; i < 5; i++) do_tick("paused_hold");
    pulse_pause();
    chk("paused_clr", {15'd0, paused}, {15'd0, paused_exp});
    do_tick("resume_1");
    do_tick("resume_2");

    // Pause toggle in the tick cycle: tick still counts.
    model_tick();
    exp_q.push_back(pack(m_exp, s_exp));
    @(negedge clock) tick_in = 1'b1;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    chk("coinc_pulse", {15'd0, tick_pulse}, 16'd1);
    pause_toggle = 1'b1;
    @(negedge clock) pause_toggle = 1'b0; tick_in = 1'b0;
    paused_exp = 1'b1;
    repeat (2) @(negedge clock);
    chk_time("pause_coinc_counted");
    chk("pause_coinc_paused", {15'd0, paused}, 16'd1);
    pulse_pause();

    // Clear wins over a coincident tick and leaves paused alone.
    set_time(12, 34);
    exp_q.push_back(pack(0, 0));
    @(negedge clock) tick_in = 1'b1;
    @(posedge clock); @(posedge clock);
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0; tick_in = 1'b0;
    m_exp = 0; s_exp = 0;
    repeat (2) @(negedge clock);
    chk_time("clear_coinc");
    chk("clear_paused", {15'd0, paused}, {15'd0, paused_exp});

    // Async reset mid-count discards a tick already in the synchroniser.
    set_time(7, 7);
    chk("pre_reset_07_07", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0707);
    @(negedge clock) tick_in = 1'b1;
    @(posedge clock); @(posedge clock);
    #2 reset_n = 1'b0; tick_in = 1'b0;
    #1;
    chk("async_reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    chk("async_reset_pulse", {15'd0, tick_pulse}, 16'd0);
    p0 = pulse_cnt;
    @(negedge clock) reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    chk("post_reset_no_pulse", 16'(pulse_cnt - p0), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
